lcd_spi_tx_fifo: RTL
====================

Name: lcd_spi_tx_fifo

Overview:
Parametrised SPI write engine for ST7735S-class LCD controllers, the successor of the single-byte LCD SPI driver. Adds an input FIFO of {D/CX, data} words with a ready/valid handshake, generic word width, selectable clock polarity, and optional chip-select burst across back-to-back words. Sits between the display init/frame-streaming logic and the LCD pins.

Parameters:
CLK_DIV, 100, i_clk cycles per SPI half-bit (>=1); SPI bit period = 2*CLK_DIV cycles
DATA_W, 8, bits per word, 8..16, sent MSB first
FIFO_DEPTH, 16, FIFO entries, power of 2, >=2
CPOL, 0, SCL idle level; data is always sampled by the panel on the first edge after CS low (CPHA=0)
CS_BURST, 1, 1 = keep CSX low between words while FIFO non-empty; 0 = release CSX after every word
CS_GAP_CLKS, 4, i_clk cycles CSX is held high between words when CSX is released (>=1)

Ports:
i_clk  in  1  system clock
i_nrst  in  1  asynchronous active-low reset
i_valid  in  1  push request
i_dc  in  1  D/CX for the word: 0 = command, 1 = data
i_data  in  DATA_W  word to send
o_ready  out  1  FIFO not full; push accepted when i_valid & o_ready
i_flush  in  1  discard all queued (not in-flight) words
o_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
o_busy  out  1  word in flight or FIFO non-empty
o_spi_clk  out  1  SCL
o_spi_mosi  out  1  SDA
o_spi_dc  out  1  D/CX
o_spi_ss  out  1  CSX, active low

Behaviour:
- Reset (async, i_nrst=0): FIFO empty, o_level=0, o_ready=1, o_busy=0, o_spi_clk=CPOL, o_spi_mosi=0, o_spi_dc=0, o_spi_ss=1, state IDLE. Reset mid-word aborts the word immediately.
- FIFO: push on i_valid & o_ready. Push while full is ignored. Push and pop in the same cycle keep the level unchanged. i_flush empties the FIFO in that cycle, and flush wins over a simultaneous push. The in-flight word is never affected by flush.
- States: IDLE, LOW (setup half), HIGH (sample half), GAP.
- IDLE: if the FIFO is non-empty at cycle T, pop at T. From T+1: o_spi_ss=0, o_spi_dc=entry dc, o_spi_mosi=bit DATA_W-1. Go to LOW.
- LOW: SCL=CPOL for CLK_DIV cycles, then toggle SCL and go to HIGH. The rising edge (CPOL=0) falls at T+1+CLK_DIV*(2k+1) for bit k.
- HIGH: SCL=~CPOL for CLK_DIV cycles, then return SCL to CPOL. If bits remain, shift MOSI to the next bit and go to LOW.
- End of last bit (trailing edge at T+1+2*CLK_DIV*DATA_W):
  - If CS_BURST=1 and the FIFO is non-empty: pop in that cycle, load the new word's MSB and dc, keep ss=0, go to LOW. The stream has no idle cycles.
  - Otherwise: ss=1, mosi=0, go to GAP for CS_GAP_CLKS cycles, then IDLE. o_spi_dc holds its last value.
- Word time is 2*CLK_DIV*DATA_W cycles with CSX low. Internal half-bit counter width is $clog2(CLK_DIV); bit counter width is $clog2(DATA_W).
- o_busy = (state != IDLE) | (o_level != 0).
- o_ready and o_level are registered from FIFO pointers. Pointers are $clog2(FIFO_DEPTH)+1 bits wide, and wrap-around is handled by the extra MSB.

Optional Feature:
LCD_SPI_TXCOUNT_EN
- Defined: adds output o_tx_count [15:0], reset 0. It increments by 1 in the cycle each word's last trailing edge completes and wraps from 65535 to 0. Flushed words are not counted. A reset mid-word means that word is not counted.
- Undefined: the port and counter are absent.

Test Plan:
- CLK_DIV=2, DATA_W=8, CPOL=0; after reset push {dc=0, 0x2A} -> ss low 1 cycle after pop; MOSI 0,0,1,0,1,0,1,0 at 8 rising edges, 4 cycles apart; dc=0; ss high after 32 cycles; o_busy back to 0 after the GAP.
- CS_BURST=1; push {0,0x2A},{1,0x00},{1,0x7F} back-to-back -> ss low for a continuous 96 cycles; dc goes 0->1 at the falling edge ending byte 1; no SCL gap between words.
- CS_BURST=0, CS_GAP_CLKS=4; same 3 pushes -> three 32-cycle CS-low windows separated by 4+1 high cycles.
- FIFO_DEPTH=4; 6 consecutive pushes -> first is popped, 4 stored, o_level=4, o_ready=0; 6th is dropped; exactly 5 words appear on the bus.
- Queue 3 words, assert i_flush during word 1 bit 3 -> word 1 completes intact; o_level=0 next cycle; no further CS activity.
- Assert i_nrst=0 mid-HIGH of bit 4 -> ss=1, clk=CPOL, mosi=0, dc=0, level=0 without waiting for a clock edge; a new push after release transmits normally.

Source files
------------

// File: rtl/lcd_spi_tx_fifo.sv
// lcd_spi_tx_fifo: FIFO-fed SPI write engine for ST7735S-class LCD panels.
// Streams queued {D/CX, data} words out as CPHA=0 SPI, MSB first.
//
// Ports:
//   i_clk, i_nrst        clock, async active-low reset
//   i_valid/o_ready      push handshake for {i_dc, i_data}
//   i_flush              drop every queued word (in-flight word unaffected)
//   o_level, o_busy      FIFO occupancy, engine/FIFO activity
//   o_spi_clk/mosi/dc/ss LCD pins SCL, SDA, D/CX, CSX (active low)
//   o_tx_count           words completed (only with LCD_SPI_TXCOUNT_EN)
//
// Optional build macro: LCD_SPI_TXCOUNT_EN adds o_tx_count [15:0].

module lcd_spi_tx_fifo #(
  parameter int CLK_DIV     = 100,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter bit CPOL        = 1'b0,
  parameter bit CS_BURST    = 1'b1,
  parameter int CS_GAP_CLKS = 4
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_valid,
  input  logic                               i_dc,
  input  logic [DATA_W-1:0]                  i_data,
  output logic                               o_ready,
  input  logic                               i_flush,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
  output logic                               o_busy,
  output logic                               o_spi_clk,
  output logic                               o_spi_mosi,
  output logic                               o_spi_dc,
  output logic                               o_spi_ss
`ifdef LCD_SPI_TXCOUNT_EN
  ,
  output logic [15:0]                        o_tx_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam int GW = (CS_GAP_CLKS > 1) ? $clog2(CS_GAP_CLKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } state_t;

  state_t state_q;
  state_t state_d;

  // FIFO storage and pointers (extra MSB tells full from empty)
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [AW:0]     wptr_q;
  logic [AW:0]     rptr_q;
  logic [AW:0]     wptr_d;
  logic [AW:0]     rptr_d;
  logic [AW:0]     fill_d;
  logic            empty;
  logic            push;
  logic [DATA_W:0] head;

  // Serializer state
  logic [HW-1:0]     hcnt_q;
  logic [BW-1:0]     bcnt_q;
  logic [GW-1:0]     gcnt_q;
  logic [DATA_W-1:0] shreg_q;

  // Control strobes
  logic half_end;
  logic last_bit;
  logic gap_end;
  logic pop;
  logic shift;
  logic word_end;

  // ---------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------
  assign empty = (wptr_q == rptr_q);
  assign head  = mem[rptr_q[AW-1:0]];

  // Flush wins over a push in the same cycle.
  assign push = i_valid & o_ready & ~i_flush;

  assign wptr_d = wptr_q + {{AW{1'b0}}, push};

  // A flush still lets a same-cycle pop take the head word.
  assign rptr_d = i_flush ? wptr_q
                          : rptr_q + {{AW{1'b0}}, pop};

  assign fill_d = wptr_d - rptr_d;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= {i_dc, i_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      o_level <= '0;
      o_ready <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      o_level <= LW'(fill_d);
      o_ready <= (fill_d != (AW+1)'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign half_end = (hcnt_q == HW'(CLK_DIV - 1));
  assign last_bit = (bcnt_q == BW'(DATA_W - 1));
  assign gap_end  = (gcnt_q == GW'(CS_GAP_CLKS - 1));

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = LOW;
      end
      LOW: begin
        if (half_end) state_d = HIGH;
      end
      HIGH: begin
        if (half_end) begin
          if (!last_bit) state_d = LOW;
          else if (pop)  state_d = LOW;
          else           state_d = GAP;
        end
      end
      GAP: begin
        if (gap_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: output strobes
  // ---------------------------------------------------------------
  always_comb begin
    pop      = 1'b0;
    shift    = 1'b0;
    word_end = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        pop = ~empty;
      end
      state_q == HIGH: begin
        shift    = half_end & ~last_bit;
        word_end = half_end & last_bit;
        // Burst: chain the next word on the trailing edge.
        pop      = half_end & last_bit & CS_BURST & ~empty;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Serializer datapath
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      hcnt_q <= '0;
    end else if ((state_q == LOW || state_q == HIGH) && !half_end) begin
      hcnt_q <= hcnt_q + HW'(1);
    end else begin
      hcnt_q <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      bcnt_q <= '0;
    end else if (pop || word_end) begin
      bcnt_q <= '0;
    end else if (shift) begin
      bcnt_q <= bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      gcnt_q <= '0;
    end else if (state_q == GAP && !gap_end) begin
      gcnt_q <= gcnt_q + GW'(1);
    end else begin
      gcnt_q <= '0;
    end
  end

  // MOSI is the shifter MSB; clearing the shifter parks SDA low.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      shreg_q <= '0;
    end else if (pop) begin
      shreg_q <= head[DATA_W-1:0];
    end else if (shift) begin
      shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
    end else if (word_end) begin
      shreg_q <= '0;
    end
  end

  assign o_spi_mosi = shreg_q[DATA_W-1];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_spi_clk <= CPOL;
    end else if (state_q == LOW && half_end) begin
      o_spi_clk <= ~CPOL;
    end else if (state_q == HIGH && half_end) begin
      o_spi_clk <= CPOL;
    end
  end

  // D/CX holds its last value through GAP and IDLE.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_spi_dc <= 1'b0;
    end else if (pop) begin
      o_spi_dc <= head[DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_spi_ss <= 1'b1;
    end else if (pop) begin
      o_spi_ss <= 1'b0;
    end else if (word_end) begin
      o_spi_ss <= 1'b1;
    end
  end

  assign o_busy = (state_q != IDLE) | (o_level != '0);

`ifdef LCD_SPI_TXCOUNT_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_tx_count <= '0;
    end else if (word_end) begin
      o_tx_count <= o_tx_count + 16'd1;
    end
  end
`endif

endmodule
